// File: rtl/edge_detect_pkg.sv
// Shared edge-kind encoding and the per-lane edge rule used by edge_detect.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_RISING,
    EDGE_FALLING,
    EDGE_DUAL
  } edge_kind_e;

  function automatic logic lane_edge(edge_kind_e kind, logic cur, logic prev);
    logic result;
    case (kind)
      EDGE_RISING:  result = cur & ~prev;
      EDGE_FALLING: result = ~cur & prev;
      EDGE_DUAL:    result = cur ^ prev;
      default:      result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Per-bit edge detector: turns level inputs into registered one-clock strobes
// on rising, falling or both edges, with an enable that freezes the history.
module edge_detect
  import edge_detect_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter string EDGE_TYPE  = "RISING"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [DATA_WIDTH-1:0] pulse_out
);

  localparam edge_kind_e KIND = (EDGE_TYPE == "FALLING") ? EDGE_FALLING :
                                (EDGE_TYPE == "DUAL")    ? EDGE_DUAL    :
                                                           EDGE_RISING;

  if (EDGE_TYPE != "RISING" && EDGE_TYPE != "FALLING" && EDGE_TYPE != "DUAL") begin : g_bad_edge_type
    $error("edge_detect: unsupported EDGE_TYPE '%s'", EDGE_TYPE);
  end

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("edge_detect: DATA_WIDTH must be >= 1");
  end

  logic [DATA_WIDTH-1:0] r_in_q;
  logic                  r_primed;
  logic [DATA_WIDTH-1:0] r_pulse;
  logic [DATA_WIDTH-1:0] w_edge;

  // NOTE: give every always_comb output a default before any branch or loop,
  // so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_edge = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_edge[i] = lane_edge(KIND, in[i], r_in_q[i]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q   <= '0;
      r_primed <= 1'b0;
      r_pulse  <= '0;
    end else if (en) begin
      r_in_q   <= in;
      r_primed <= 1'b1;
      // History is meaningless until the first enabled sample after reset.
      r_pulse  <= r_primed ? w_edge : '0;
    end else begin
      r_pulse  <= '0;
    end
  end

  assign pulse_out = r_pulse;

endmodule

// File: tb/tb_edge_detect.sv
// Self-checking bench: RISING/FALLING/DUAL 8-bit instances plus a 1-bit DUAL
// instance, driven by a vector table, hand sequences and random stimulus.
module tb_edge_detect;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] in;
  logic       in1;
  logic [7:0] p_rise;
  logic [7:0] p_fall;
  logic [7:0] p_dual;
  logic       p_one;

  int checks;
  int failures;

  edge_detect #(.DATA_WIDTH(8), .EDGE_TYPE("RISING")) u_rise (
    .clk(clk), .rst(rst), .en(en), .in(in), .pulse_out(p_rise));
  edge_detect #(.DATA_WIDTH(8), .EDGE_TYPE("FALLING")) u_fall (
    .clk(clk), .rst(rst), .en(en), .in(in), .pulse_out(p_fall));
  edge_detect #(.DATA_WIDTH(8), .EDGE_TYPE("DUAL")) u_dual (
    .clk(clk), .rst(rst), .en(en), .in(in), .pulse_out(p_dual));
  edge_detect #(.DATA_WIDTH(1), .EDGE_TYPE("DUAL")) u_one (
    .clk(clk), .rst(rst), .en(en), .in(in1), .pulse_out(p_one));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the list of enabled samples seen since the last reset.
  logic [7:0] hist8[$];
  logic       hist1[$];
  logic [7:0] exp_rise, exp_fall, exp_dual;
  logic       exp_one;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic [7:0] d, input logic d1);
    logic [7:0] prev;
    exp_rise = 8'h00;
    exp_fall = 8'h00;
    exp_dual = 8'h00;
    exp_one  = 1'b0;
    if (r) begin
      hist8.delete();
      hist1.delete();
    end else if (e) begin
      if (hist8.size() > 0) begin
        prev = hist8[$];
        for (int b = 0; b < 8; b++) begin
          exp_rise[b] = (d[b] == 1'b1) && (prev[b] == 1'b0);
          exp_fall[b] = (d[b] == 1'b0) && (prev[b] == 1'b1);
          exp_dual[b] = d[b] != prev[b];
        end
        exp_one = d1 != hist1[$];
      end
      hist8.push_back(d);
      hist1.push_back(d1);
      if (hist8.size() > 4) begin
        void'(hist8.pop_front());
        void'(hist1.pop_front());
      end
    end
  endtask

  // Apply one cycle of stimulus, then compare every instance to the model.
  task automatic step(input logic r, input logic e, input logic [7:0] d, input logic d1);
    rst = r;
    en  = e;
    in  = d;
    in1 = d1;
    @(posedge clk);
    model_update(r, e, d, d1);
    #1;
    check("model_rise", p_rise, exp_rise);
    check("model_fall", p_fall, exp_fall);
    check("model_dual", p_dual, exp_dual);
    check("model_one", {7'b0, p_one}, {7'b0, exp_one});
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] d;
    logic [7:0] x_dual;
    logic [7:0] x_rise;
    logic [7:0] x_fall;
  } vec_t;

  vec_t vecs[20];

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    en  = 1'b0;
    in  = 8'h00;
    in1 = 1'b0;

    vecs = '{
      '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00},  // reset
      '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00},
      '{1'b0, 1'b1, 8'hAA, 8'h00, 8'h00, 8'h00},  // priming sample
      '{1'b0, 1'b1, 8'h55, 8'hFF, 8'h55, 8'hAA},
      '{1'b0, 1'b1, 8'hF0, 8'hA5, 8'hA0, 8'h05},
      '{1'b0, 1'b1, 8'h0F, 8'hFF, 8'h0F, 8'hF0},
      '{1'b0, 1'b1, 8'h0F, 8'h00, 8'h00, 8'h00},  // hold
      '{1'b0, 1'b1, 8'h00, 8'h0F, 8'h00, 8'h0F},
      '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00},  // change while disabled
      '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00},
      '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00},  // re-enable sees 00->FF
      '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00},
      '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF},
      '{1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00},  // reset beats pending change
      '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00},  // re-primes, no pulse
      '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00},
      '{1'b0, 1'b1, 8'h3C, 8'hC3, 8'h00, 8'hC3},
      '{1'b0, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h00},
      '{1'b0, 1'b1, 8'hC3, 8'hFF, 8'hC3, 8'h3C},
      '{1'b0, 1'b1, 8'hC3, 8'h00, 8'h00, 8'h00}
    };

    for (int v = 0; v < 20; v++) begin
      step(vecs[v].r, vecs[v].e, vecs[v].d, vecs[v].d[0]);
      check($sformatf("vec%0d_dual", v), p_dual, vecs[v].x_dual);
      check($sformatf("vec%0d_rise", v), p_rise, vecs[v].x_rise);
      check($sformatf("vec%0d_fall", v), p_fall, vecs[v].x_fall);
    end

    // One-bit DUAL lane toggling every cycle stays high once primed.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("one_reset", {7'b0, p_one}, 8'h00);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("one_prime", {7'b0, p_one}, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00, (i % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("one_toggle%0d", i), {7'b0, p_one}, 8'h01);
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check("one_hold", {7'b0, p_one}, 8'h00);

    // Disable with a pending change, then reset before re-enabling: no pulse.
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'hFF, 1'b1);
    step(1'b1, 1'b0, 8'hFF, 1'b1);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    check("rst_clears_history", p_dual, 8'h00);

    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(31) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(3) != 0) ? 1'b1 : 1'b0,
           8'($urandom),
           1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
